// File: rtl/nibble_pkg.sv
// Shared constants, opcodes and FSM state encoding for the 4-bit execute stage.
package nibble_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned PC_W  = 12;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_ANDI  = 4'h4;
  localparam logic [3:0] OP_NANDI = 4'h5;
  localparam logic [3:0] OP_CMPI  = 4'h6;
  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [3:0] OP_OUT   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JC    = 4'hA;
  localparam logic [3:0] OP_JNC   = 4'hB;
  localparam logic [3:0] OP_JZ    = 4'hC;
  localparam logic [3:0] OP_JNZ   = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_RSV   = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_JUMP  = 3'd2,
    S_SKIP  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  function automatic logic is_jump(logic [3:0] op);
    return (op >= OP_JMP) && (op <= OP_JNZ);
  endfunction

endpackage

// File: rtl/nibble_exec_if.sv
// Fetch-side and I/O signals of the execute stage; master is the execute stage itself.
interface nibble_exec_if #(
  parameter int unsigned PC_W = 12
);
  logic [3:0]      instr;
  logic [3:0]      oprnd;
  logic [7:0]      program_byte;
  logic [3:0]      in_data;
  logic            fetch_en;
  logic            pc_load;
  logic [PC_W-1:0] pc_loadvalue;
  logic [3:0]      acc;
  logic            flag_c;
  logic            flag_z;
  logic [3:0]      out_data;
  logic            out_we;
  logic            halted;

  modport master (
    input  instr, oprnd, program_byte, in_data,
    output fetch_en, pc_load, pc_loadvalue, acc, flag_c, flag_z, out_data, out_we, halted
  );

  modport slave (
    output instr, oprnd, program_byte, in_data,
    input  fetch_en, pc_load, pc_loadvalue, acc, flag_c, flag_z, out_data, out_we, halted
  );
endinterface

// File: rtl/nibble_alu.sv
// Combinational 4-bit ALU. Rotate-through-carry on opcode F exists only with EXEC_SHIFT_EN.
module nibble_alu
  import nibble_pkg::*;
(
  input  logic [NIB_W-1:0] op,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             c_in,
  output logic [NIB_W-1:0] result,
  output logic             c_out,
  output logic             z_out
);

  logic [NIB_W:0] sum;
  logic [NIB_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // diff[NIB_W] is the borrow; carry flag is its inverse
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    c_out  = c_in;
    case (op)
      OP_LIT, OP_IN:    result = b;
      OP_ADDI:          {c_out, result} = sum;
      OP_SUBI, OP_CMPI: begin
        result = diff[NIB_W-1:0];
        c_out  = ~diff[NIB_W];
      end
      OP_ANDI:          result = a & b;
      OP_NANDI:         result = ~(a & b);
`ifdef EXEC_SHIFT_EN
      OP_RSV: begin
        if (b[0]) {result, c_out} = {c_in, a};
        else      {c_out, result} = {a, c_in};
      end
`endif
      default: ;
    endcase
  end

  assign z_out = (result == '0);

endmodule

// File: rtl/nibble_exec.sv
// Execute/control stage: fetch/exec sequencing, accumulator, flags, jumps and I/O port.
// Optional feature macro: EXEC_SHIFT_EN (opcode F = rotate through carry).
module nibble_exec #(
  parameter int unsigned PC_W    = 12,
  parameter logic [3:0]  OUT_RST = 4'h0
) (
  input logic           clk,
  input logic           rst,
  nibble_exec_if.master bus
);
  import nibble_pkg::*;

  state_e           state_q, state_d;
  logic [NIB_W-1:0] acc_q, out_q, alu_b, alu_res;
  logic             c_q, z_q, out_we_q, alu_c, alu_z;
  logic [PC_W-1:0]  pc_lv_q;
  logic             exec, jump_op, taken, acc_we, c_we, z_we;
  logic             fetch_en, pc_load, halted;

  assign exec    = (state_q == S_EXEC);
  assign jump_op = is_jump(bus.instr);
  assign alu_b   = (bus.instr == OP_IN) ? bus.in_data : bus.oprnd;

  nibble_alu u_alu (
    .op    (bus.instr),
    .a     (acc_q),
    .b     (alu_b),
    .c_in  (c_q),
    .result(alu_res),
    .c_out (alu_c),
    .z_out (alu_z)
  );

  // Jump conditions look at the flags as they stand before this instruction commits
  always_comb begin
    taken  = 1'b0;
    acc_we = 1'b0;
    c_we   = 1'b0;
    case (bus.instr)
      OP_LIT, OP_ANDI, OP_NANDI, OP_IN: acc_we = 1'b1;
      OP_ADDI, OP_SUBI: begin
        acc_we = 1'b1;
        c_we   = 1'b1;
      end
      OP_CMPI: c_we  = 1'b1;
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c_q;
      OP_JNC:  taken = ~c_q;
      OP_JZ:   taken = z_q;
      OP_JNZ:  taken = ~z_q;
`ifdef EXEC_SHIFT_EN
      OP_RSV: begin
        acc_we = 1'b1;
        c_we   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign z_we = acc_we | (bus.instr == OP_CMPI);

  always_comb begin
    state_d  = state_q;
    fetch_en = 1'b0;
    pc_load  = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        fetch_en = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (jump_op)                    state_d = taken ? S_JUMP : S_SKIP;
        else if (bus.instr == OP_HALT)  state_d = S_HALT;
        else                            state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
      // Steps the PC over the unused second byte of a not-taken jump
      S_SKIP: begin
        fetch_en = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  halted  = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      acc_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      out_q    <= OUT_RST;
      out_we_q <= 1'b0;
      pc_lv_q  <= '0;
    end else begin
      state_q  <= state_d;
      out_we_q <= exec && (bus.instr == OP_OUT);
      if (exec) begin
        if (acc_we)               acc_q   <= alu_res;
        if (c_we)                 c_q     <= alu_c;
        if (z_we)                 z_q     <= alu_z;
        if (bus.instr == OP_OUT)  out_q   <= acc_q;
        if (jump_op)              pc_lv_q <= PC_W'({bus.oprnd, bus.program_byte});
      end
    end
  end

  assign bus.fetch_en     = fetch_en;
  assign bus.pc_load      = pc_load;
  assign bus.pc_loadvalue = pc_lv_q;
  assign bus.acc          = acc_q;
  assign bus.flag_c       = c_q;
  assign bus.flag_z       = z_q;
  assign bus.out_data     = out_q;
  assign bus.out_we       = out_we_q;
  assign bus.halted       = halted;

endmodule

// File: doc/nibble_exec.md
Name: nibble_exec

Overview:
- Execute/control stage that sits directly downstream of the program-counter/ROM/fetch block.
- Consumes the latched instr/oprnd nibbles and the live program_byte from that block.
- Sequences the 4-bit machine through fetch/execute phases and runs a 4-bit ALU with accumulator, carry and zero flags.
- Drives the counter/fetch enable and the PC load path for jumps, and owns a 4-bit input port and a 4-bit output port.

Parameters:
PC_W, 12, program-counter / jump-target width; target = {oprnd, program_byte}, so PC_W must equal 12.
OUT_RST, 4'h0, reset value of out_data.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
instr  input  4  opcode from fetch register.
oprnd  input  4  operand from fetch register.
program_byte  input  8  ROM data at current PC; second byte of jump instructions.
in_data  input  4  external input port.
fetch_en  output  1  drives PC enable and fetch enable; combinational from state.
pc_load  output  1  PC load strobe; combinational from state.
pc_loadvalue  output  12  registered jump target.
acc  output  4  accumulator.
flag_c  output  1  carry flag.
flag_z  output  1  zero flag.
out_data  output  4  registered output port.
out_we  output  1  one-cycle pulse when out_data is written.
halted  output  1  high in S_HALT.

Behaviour:
- Reset values: state S_FETCH, acc 0, flag_c 0, flag_z 0, out_data OUT_RST, out_we 0, pc_loadvalue 0, halted 0. Reset mid-instruction abandons the instruction; nothing is committed.
- States and outputs:
  - S_FETCH: fetch_en=1. Upstream latches ROM[pc] and increments pc on the same edge. Next state S_EXEC.
  - S_EXEC: instr/oprnd are valid; program_byte = ROM[pc] = the byte after the opcode. Decodes and commits on exit. Next state S_FETCH, except as listed below.
  - S_JUMP: pc_load=1 and fetch_en=0 for exactly one cycle. Next state S_FETCH.
  - S_SKIP: fetch_en=1 for one cycle, to step over the unused second byte of a not-taken jump. Next state S_FETCH; the next S_FETCH overwrites the fetch register.
  - S_HALT: fetch_en=0, pc_load=0, halted=1. Held until rst.
- Opcodes (commit at the S_EXEC exit edge):
  - 0 NOP.
  - 1 LIT: acc=oprnd.
  - 2 ADDI: {c,acc}=acc+oprnd.
  - 3 SUBI: acc=acc-oprnd; c=1 when no borrow (acc>=oprnd).
  - 4 ANDI.
  - 5 NANDI.
  - 6 CMPI: flags as SUBI, acc unchanged.
  - 7 IN: acc=in_data.
  - 8 OUT: out_data=acc; out_we=1 for the following cycle only.
  - 9 JMP.
  - A JC.
  - B JNC.
  - C JZ.
  - D JNZ.
  - E HALT -> S_HALT.
  - F: reserved, see Optional Feature.
- Jumps (9-D): pc_loadvalue={oprnd, program_byte}, latched in S_EXEC.
  - Taken -> S_JUMP.
  - Not taken -> S_SKIP.
  - Conditions use flags as they are at S_EXEC, before any update.
- Flag updates:
  - flag_z = (new acc==0) on LIT, ADDI, SUBI, ANDI, NANDI, IN and shifts.
  - On CMPI, flag_z = (acc-oprnd==0).
  - flag_c is updated only by ADDI, SUBI, CMPI and shifts.
  - All other ops preserve both flags.
- Arithmetic is 4-bit and wraps: F+1 -> acc 0, c 1, z 1.
- Jump to the current address (self-loop) is legal and repeats indefinitely.
- Cycle counts: non-jump instruction = 2 cycles; jump = 3 cycles, taken or not.

Optional Feature:
- Macro EXEC_SHIFT_EN.
- Defined: opcode F is a rotate through carry.
  - oprnd[0]=0: left, {c,acc} = {acc,c}.
  - oprnd[0]=1: right, {acc,c} = {c,acc}.
  - Updates c and z.
- Undefined: opcode F behaves as NOP; no shift logic is synthesised.

Decomposition:
- Shared package nibble_pkg holds:
  - opcode localparams OP_NOP..OP_RSV;
  - state encoding S_FETCH, S_EXEC, S_JUMP, S_SKIP, S_HALT (3-bit);
  - NIB_W=4 and PC_W=12 constants.
- One sub-module, nibble_alu: combinational; inputs op, a, b, c_in; outputs result, c_out, z_out.
- The FSM, accumulator and flag/output registers stay in nibble_exec.

Test Plan:
- Reset then instr=1, oprnd=A -> fetch_en pattern 1,0; after S_EXEC acc=A, z=0; out_data=0 throughout.
- LIT F then ADDI 1 -> acc=0, c=1, z=1. Follow with JC, oprnd=3, program_byte=45 -> pc_load high exactly one cycle with pc_loadvalue=345, then fetch_en=1.
- SUBI: acc=3 minus 5 -> acc=E, c=0, z=0. Then JNC not-taken case via JC: pc_load stays 0, S_SKIP gives exactly one fetch_en pulse, 3-cycle instruction.
- in_data=9, IN then OUT -> acc=9, out_data=9, out_we high exactly one cycle.
- HALT -> halted=1, fetch_en=0 for 20 cycles. Assert rst mid-S_JUMP in a separate run -> pc_load drops immediately and all registers return to reset values.
- With EXEC_SHIFT_EN: acc=9, c=0, F with oprnd=0 -> acc=2, c=1; then F with oprnd=1 -> acc=9, c=0. Without the macro, F leaves acc and flags unchanged.
